// File: rtl/cdc_pkg.sv
// Shared types and width helpers for the source-side CDC request queue.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   src_q_state_t : request FSM states (IDLE, WAIT_BUSY, WAIT_DONE)
//   ptr_w()       : FIFO pointer width for a given depth
//   lvl_w()       : FIFO occupancy width for a given depth (holds 0..DEPTH)
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } src_q_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_sync_fifo.sv
// Single-clock FIFO holding words waiting for the CDC handshake.
// Latency: a pushed word is visible at head_o one cycle after the push edge.
// Backpressure: push_i ignored when full, pop_i ignored when empty.
//
// Ports:
//   source_clk, source_reset_n : clock, async active-low reset
//   push_i / data_i            : write request and word
//   pop_i                      : discard the head word
//   head_o                     : oldest stored word (valid when level_o != 0)
//   level_o                    : occupancy, 0..DEPTH
module cdc_sync_fifo
  import cdc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      source_clk,
  input  logic                      source_reset_n,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_o,
  output logic [lvl_w(DEPTH)-1:0]   level_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign do_push = push_i && (level_q != LW'(DEPTH));
  assign do_pop  = pop_i  && (level_q != '0);

  // DEPTH is a power of two, so pointers wrap naturally at PW bits.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset: contents are only read behind a non-zero level.
  always_ff @(posedge source_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/cdc_src_req_queue.sv
// Source-domain request queue: buffers words and issues one handshake strobe each.
// Latency: strobe in the cycle after the edge following a push into an idle, empty queue.
// Backpressure: in_ready low while full; words held until the crossing completes.
//
// Ports:
//   source_clk, source_reset_n : clock, async active-low reset
//   in_valid/in_ready/in_data  : upstream valid/ready word input
//   hs_strobe                  : one-cycle request pulse to the crossing
//   hs_stall                   : crossing busy (already synchronised), high = busy
//   hs_data                    : bundled data, stable from strobe until completion
//   level                      : FIFO occupancy
//   busy                       : FSM not in IDLE
//   err_timeout                : sticky abort flag, only with CDC_SRC_TIMEOUT_EN
// Optional feature macro: CDC_SRC_TIMEOUT_EN (handshake abort after TIMEOUT_CYCLES).
module cdc_src_req_queue
  import cdc_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    source_clk,
  input  logic                    source_reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    hs_strobe,
  input  logic                    hs_stall,
  output logic [DATA_W-1:0]       hs_data,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    busy
`ifdef CDC_SRC_TIMEOUT_EN
  ,
  output logic                    err_timeout
`endif
);

  localparam int LW = lvl_w(DEPTH);

  src_q_state_t      state_q, state_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] hs_data_q, hs_data_d;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     fifo_level;
  logic              push, pop, err_set, timeout_hit;

  // in_ready depends on the registered level only, so a pop cannot raise it
  // in the same cycle and hs_stall has no path to it.
  assign in_ready = (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;

  cdc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .source_clk     (source_clk),
    .source_reset_n (source_reset_n),
    .push_i         (push),
    .data_i         (in_data),
    .pop_i          (pop),
    .head_o         (head),
    .level_o        (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    strobe_d  = 1'b0;
    hs_data_d = hs_data_q;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_level != '0) && !hs_stall) begin
          hs_data_d = head;
          strobe_d  = 1'b1;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (timeout_hit) begin
          pop     = 1'b1;
          err_set = 1'b1;
          state_d = IDLE;
        end else if (hs_stall) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A genuine completion wins over an abort landing on the same edge.
        if (!hs_stall) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          pop     = 1'b1;
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      state_q   <= IDLE;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      hs_data_q <= '0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      hs_data_q <= hs_data_d;
    end
  end

`ifdef CDC_SRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q;

  // Counter is zero on entry to WAIT_BUSY, so the abort edge is the
  // TIMEOUT_CYCLES-th edge after the strobe edge.
  assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if ((state_q != IDLE) && (state_d != IDLE)) to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_q | err_set;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = err_set ^ (^TIMEOUT_CYCLES);
`endif

  assign hs_strobe = strobe_q;
  assign hs_data   = hs_data_q;
  assign level     = fifo_level;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cdc_src_req_queue.sv
// Directed bench for cdc_src_req_queue.
// Stimulus drives inputs 1 time unit after the rising edge, outputs sampled there too.
// A negedge monitor logs every strobe and any hs_data change outside a strobe.
module tb_cdc_src_req_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef CDC_SRC_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic              source_clk     = 1'b0;
  logic              source_reset_n = 1'b0;
  logic              in_valid       = 1'b0;
  logic              hs_stall       = 1'b0;
  logic [DATA_W-1:0] in_data        = '0;
  logic              in_ready, hs_strobe, busy;
  logic [DATA_W-1:0] hs_data;
  logic [2:0]        level;
`ifdef CDC_SRC_TIMEOUT_EN
  logic              err_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  int                strobe_cnt = 0;
  int                chg_cnt    = 0;
  logic [DATA_W-1:0] last_hs    = '0;
  logic [DATA_W-1:0] strobe_log [$];

  always #5 source_clk = ~source_clk;

  cdc_src_req_queue #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .source_clk     (source_clk),
    .source_reset_n (source_reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .hs_strobe      (hs_strobe),
    .hs_stall       (hs_stall),
    .hs_data        (hs_data),
    .level          (level),
    .busy           (busy)
`ifdef CDC_SRC_TIMEOUT_EN
    ,
    .err_timeout    (err_timeout)
`endif
  );

  always @(negedge source_clk) begin
    if (!source_reset_n) begin
      last_hs <= '0;
    end else begin
      if (hs_strobe) begin
        strobe_cnt <= strobe_cnt + 1;
        strobe_log.push_back(hs_data);
      end else if (hs_data !== last_hs) begin
        chg_cnt <= chg_cnt + 1;
      end
      last_hs <= hs_data;
    end
  end

  task automatic tick;
    @(posedge source_clk);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b0; hs_stall = 1'b0; source_reset_n = 1'b0;
    repeat (2) @(negedge source_clk);
    checks++; if (hs_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b want 0", hs_strobe); end
    checks++; if (hs_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", hs_data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef CDC_SRC_TIMEOUT_EN
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_timeout); end
`endif
    source_reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    int sb, cb;
    sb = strobe_cnt; cb = chg_cnt;
    hs_stall = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    tick;
    in_valid = 1'b0;
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level_push: got %0d want 1", level); end
    checks++; if (hs_strobe !== 1'b0) begin failures++; $display("FAIL single_early_strobe: got %b want 0", hs_strobe); end
    tick;
    checks++; if (hs_strobe !== 1'b1) begin failures++; $display("FAIL single_strobe: got %b want 1", hs_strobe); end
    checks++; if (hs_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data: got %h want a5a50001", hs_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    hs_stall = 1'b1;
    repeat (3) tick;
    checks++; if (hs_strobe !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_stalled: got strobe=%b busy=%b want 0/1", hs_strobe, busy); end
    hs_stall = 1'b0;
    tick;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level_pop: got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", busy); end
    repeat (3) tick;
    checks++; if (strobe_cnt - sb != 1) begin failures++; $display("FAIL single_strobe_count: got %0d want 1", strobe_cnt - sb); end
    checks++; if (chg_cnt != cb) begin failures++; $display("FAIL single_data_hold: got %0d changes want 0", chg_cnt - cb); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] w [4];
    int sb, cb, lb, n;
    w = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    in_valid = 1'b0; hs_stall = 1'b1; source_reset_n = 1'b0;
    @(negedge source_clk);
    source_reset_n = 1'b1;
    tick;
    sb = strobe_cnt; cb = chg_cnt; lb = strobe_log.size();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick;
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL b2b_full_level: got %0d want 4", level); end
    repeat (3) tick;
    checks++; if (strobe_cnt != sb) begin failures++; $display("FAIL b2b_no_strobe_stalled: got %0d want 0", strobe_cnt - sb); end
    hs_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (hs_strobe !== 1'b1 && n < 20) begin tick; n++; end
      checks++; if (hs_strobe !== 1'b1) begin failures++; $display("FAIL b2b_wait_strobe%0d: got 0 want 1 within 20 cycles", i); end
      checks++; if (hs_data !== w[i]) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", i, hs_data, w[i]); end
      hs_stall = 1'b1;
      repeat (2) tick;
      hs_stall = 1'b0;
    end
    repeat (4) tick;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL b2b_drained: got %0d want 0", level); end
    checks++; if (strobe_cnt - sb != 4) begin failures++; $display("FAIL b2b_strobe_count: got %0d want 4", strobe_cnt - sb); end
    checks++; if (chg_cnt != cb) begin failures++; $display("FAIL b2b_data_hold: got %0d changes want 0", chg_cnt - cb); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (strobe_log[lb+i] !== w[i]) begin failures++; $display("FAIL b2b_order%0d: got %h want %h", i, strobe_log[lb+i], w[i]); end
    end
  endtask

  task automatic test_full_refuse;
    logic [DATA_W-1:0] w [5];
    int sb, cb, n;
    w = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
    sb = strobe_cnt; cb = chg_cnt;
    hs_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick;
    end
    checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin failures++; $display("FAIL full_state: got ready=%b level=%0d want 0/4", in_ready, level); end
    in_data = w[4];
    hs_stall = 1'b1;
    repeat (5) tick;
    checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL full_refused: got level=%0d ready=%b want 4/0", level, in_ready); end
    hs_stall = 1'b0;
    tick;
    checks++; if (level !== 3'd3 || in_ready !== 1'b1) begin failures++; $display("FAIL full_first_pop: got level=%0d ready=%b want 3/1", level, in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_fifth_push: got %0d want 4", level); end
    checks++; if (hs_strobe !== 1'b1 || hs_data !== w[1]) begin failures++; $display("FAIL full_second_strobe: got %b/%h want 1/%h", hs_strobe, hs_data, w[1]); end
    for (int i = 2; i < 5; i++) begin
      hs_stall = 1'b1;
      repeat (5) tick;
      hs_stall = 1'b0;
      n = 0;
      while (hs_strobe !== 1'b1 && n < 20) begin tick; n++; end
      checks++; if (hs_strobe !== 1'b1 || hs_data !== w[i]) begin failures++; $display("FAIL full_data%0d: got %b/%h want 1/%h", i, hs_strobe, hs_data, w[i]); end
    end
    hs_stall = 1'b1;
    repeat (5) tick;
    hs_stall = 1'b0;
    repeat (3) tick;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL full_drained: got %0d want 0", level); end
    checks++; if (strobe_cnt - sb != 5) begin failures++; $display("FAIL full_strobe_count: got %0d want 5", strobe_cnt - sb); end
    checks++; if (chg_cnt != cb) begin failures++; $display("FAIL full_data_hold: got %0d changes want 0", chg_cnt - cb); end
  endtask

  task automatic test_push_pop_same;
    int n;
    hs_stall = 1'b0;
    in_valid = 1'b1; in_data = 32'h0BAD_0000; tick;
    in_data = 32'h0BAD_0001; tick;
    in_valid = 1'b0;
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL pp_setup_level: got %0d want 2", level); end
    hs_stall = 1'b1; tick;
    hs_stall = 1'b0; in_valid = 1'b1; in_data = 32'h0BAD_0002; tick;
    in_valid = 1'b0;
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL pp_level_held: got %0d want 2", level); end
    tick;
    checks++; if (hs_strobe !== 1'b1 || hs_data !== 32'h0BAD_0001) begin failures++; $display("FAIL pp_next: got %b/%h want 1/0bad0001", hs_strobe, hs_data); end
    hs_stall = 1'b1; repeat (2) tick; hs_stall = 1'b0;
    n = 0;
    while (hs_strobe !== 1'b1 && n < 20) begin tick; n++; end
    checks++; if (hs_strobe !== 1'b1 || hs_data !== 32'h0BAD_0002) begin failures++; $display("FAIL pp_last: got %b/%h want 1/0bad0002", hs_strobe, hs_data); end
    hs_stall = 1'b1; repeat (2) tick; hs_stall = 1'b0;
    repeat (3) tick;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL pp_drained: got %0d want 0", level); end
  endtask

`ifdef CDC_SRC_TIMEOUT_EN
  task automatic test_timeout;
    hs_stall = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_0001; tick;
    in_data = 32'hDEAD_0002; tick;
    in_valid = 1'b0;
    hs_stall = 1'b1;
    repeat (TMO - 1) tick;
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1 || level !== 3'd2) begin failures++; $display("FAIL tmo_before: got err=%b busy=%b level=%0d want 0/1/2", err_timeout, busy, level); end
    tick;
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0 || level !== 3'd1) begin failures++; $display("FAIL tmo_abort: got err=%b busy=%b level=%0d want 1/0/1", err_timeout, busy, level); end
    hs_stall = 1'b0; tick;
    checks++; if (hs_strobe !== 1'b1 || hs_data !== 32'hDEAD_0002) begin failures++; $display("FAIL tmo_next: got %b/%h want 1/dead0002", hs_strobe, hs_data); end
    hs_stall = 1'b1; repeat (2) tick; hs_stall = 1'b0;
    repeat (3) tick;
    checks++; if (err_timeout !== 1'b1 || level !== 3'd0) begin failures++; $display("FAIL tmo_sticky: got err=%b level=%0d want 1/0", err_timeout, level); end
  endtask
`endif

  task automatic test_reset_mid;
    int sb;
    hs_stall = 1'b0;
    in_valid = 1'b1; in_data = 32'h5EED_0000; tick;
    in_data = 32'h5EED_0001; tick;
    in_data = 32'h5EED_0002; tick;
    in_valid = 1'b0;
    hs_stall = 1'b1; tick;
    checks++; if (busy !== 1'b1 || level !== 3'd3) begin failures++; $display("FAIL rmid_setup: got busy=%b level=%0d want 1/3", busy, level); end
    #2;
    source_reset_n = 1'b0;
    #1;
    checks++; if (hs_strobe !== 1'b0 || hs_data !== 32'h0) begin failures++; $display("FAIL rmid_hs: got %b/%h want 0/0", hs_strobe, hs_data); end
    checks++; if (level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_state: got level=%0d busy=%b ready=%b want 0/0/1", level, busy, in_ready); end
`ifdef CDC_SRC_TIMEOUT_EN
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rmid_err: got %b want 0", err_timeout); end
`endif
    repeat (2) @(negedge source_clk);
    source_reset_n = 1'b1;
    tick;
    sb = strobe_cnt;
    repeat (2) tick;
    hs_stall = 1'b0;
    repeat (4) tick;
    checks++; if (strobe_cnt != sb || level !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_dropped: got strobes=%0d level=%0d busy=%b want 0/0/0", strobe_cnt - sb, level, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full_refuse;
    test_push_pop_same;
`ifdef CDC_SRC_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_src_req_queue.md
# cdc_src_req_queue

Source-domain request queue feeding the single-strobe CDC handshake stage. Accepts data words from source logic over valid/ready, buffers them in a small FIFO, and issues one handshake strobe per word. Holds the word stable on a bundled-data bus until the crossing reports completion. Sits entirely in `source_clk` and is the only driver of the crossing's source strobe.

## Interface
- `DATA_W`, 32: width of each queued word.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1024: abort threshold in source cycles; used only with `CDC_SRC_TIMEOUT_EN`.

Ports:
- `source_clk`  in  1: source-domain clock.
- `source_reset_n`  in  1: reset; asynchronous, active-low.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: FIFO can accept; equals `level != DEPTH`.
- `in_data`  in  DATA_W: upstream word.
- `hs_strobe`  out  1: one-cycle request pulse to the crossing.
- `hs_stall`  in  1: crossing busy, already synchronised into `source_clk`; high = busy.
- `hs_data`  out  DATA_W: bundled data, stable from strobe until completion.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `busy`  out  1: state ≠ IDLE.
- `err_timeout`  out  1: sticky timeout flag; present only with macro.

## Operation
- Push when `in_valid && in_ready` at an edge. Pop only on completion or abort.
- Push and pop in the same cycle leave `level` unchanged.
- When full, `in_ready` is low. A pop does not raise `in_ready` in the same cycle; no combinational path from `hs_stall` to `in_ready`.
- FSM states:
  - **IDLE**: if `level != 0 && !hs_stall`, load head into `hs_data`, pulse `hs_strobe` for 1 cycle, go to WAIT_BUSY. If `hs_stall` is high, wait.
  - **WAIT_BUSY**: wait for `hs_stall` = 1 (crossing accepted), then go to WAIT_DONE.
  - **WAIT_DONE**: wait for `hs_stall` = 0, then pop head and return to IDLE.
- Exactly one strobe per word. Never a second strobe before the pop.
- `hs_data` changes only in the cycle `hs_strobe` asserts. It otherwise holds its last value.
- Reset values: `hs_strobe` 0, `hs_data` 0, `level` 0, `busy` 0, `err_timeout` 0, FSM IDLE. `in_ready` is 1 after reset because it follows `level`.
- Reset mid-transaction: the FIFO empties and all queued words are dropped. Recovery is the crossing's responsibility, since it holds stall high out of its own reset.
- Pointers wrap modulo DEPTH. `level` saturates by construction and never exceeds DEPTH.

## Timing
- Push accepted at edge k with the FIFO empty and `hs_stall` low: `hs_strobe` is high for the cycle after edge k+1.
- Minimum spacing between strobes is 3 cycles: strobe, ≥1 busy-observed cycle, ≥1 idle-observed cycle.
- Pop occurs at the edge where WAIT_DONE samples `hs_stall` = 0. The next strobe follows one cycle later if data is queued.
- All outputs are registered except `in_ready`, which is combinational from `level`.

## Configuration
- `CDC_SRC_TIMEOUT_EN`:
  - **Defined**:
    - A counter of $clog2(TIMEOUT_CYCLES+1) bits runs in WAIT_BUSY and WAIT_DONE and clears on IDLE.
    - On reaching TIMEOUT_CYCLES, the head word is popped (discarded), `err_timeout` is set (sticky until reset) and the FSM returns to IDLE.
  - **Undefined**:
    - No counter and no `err_timeout` port; the FSM waits indefinitely.

## Structure
- Package `cdc_pkg`:
  - FSM enum `src_q_state_t` (IDLE, WAIT_BUSY, WAIT_DONE).
  - Pointer/level width helper functions.
- Sub-module `cdc_sync_fifo`: single-clock FIFO with push/pop/level, parameterised by `DATA_W`/`DEPTH`.
- Top level holds the FSM, `hs_data` register and timeout counter.

## Test plan
- Single word 0xA5A5_0001 with `hs_stall` low → one `hs_strobe` 2 edges after push, `hs_data` = 0xA5A5_0001. Bench raises stall 3 cycles, drops it → `level` returns to 0, `busy` 0.
- Push 4 words back-to-back with DEPTH=4 while stall is held high from reset → `in_ready` 0 after the 4th, no strobe. Release stall → words strobed in order, each exactly once.
- `hs_stall` toggles busy/idle 5 cycles each; a 5th push is attempted while full → push refused until the first pop. `hs_data` is never altered between a strobe and its completion.
- Push and pop in the same cycle at `level` = 2 → `level` stays 2.
- Macro on, TIMEOUT_CYCLES=16, stall stuck high after a strobe → pop and `err_timeout` = 1 at cycle 16. The next word strobes once stall drops.
- Async reset asserted in WAIT_DONE with 3 queued → all outputs at reset values immediately, `level` 0.
